// File: rtl/mac_sched.sv
// ---------------------------------------------------------------------------
// mac_sched -- job sequencer and lane arbiter for one MAC processing element.
//
// Accepts a dot-product job of len_i terms, clears the MAC accumulator, then
// grants the three MAC lanes to their requesters in round-robin order, one
// term per cycle. After the final term it waits one cycle for the MAC's
// registered accumulation to settle, captures mac_acc_i into result_o and
// pulses done_o. Requesters drive the MAC data/weight inputs themselves; this
// block owns only the clear strobe, the lane valids and job framing.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_i      job request, sampled only while idle
//   len_i        term count, latched when start_i is accepted
//   abort_i      synchronous cancel, honoured in CLEAR, RUN and DRAIN
//   req_i[2:0]   per-requester "term available" (level)
//   grant_o      one-hot or zero; requester i's term is consumed when set
//   mac_clear_o  MAC accumulator clear
//   mac_valid_o  MAC lane valids, always equal to grant_o
//   mac_acc_i    MAC accumulator output
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse when result_o is updated
//   result_o     captured accumulator, held until the next completed job
// ---------------------------------------------------------------------------
module mac_sched #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic [2:0]       req_i,
  output logic [2:0]       grant_o,
  output logic             mac_clear_o,
  output logic [2:0]       mac_valid_o,
  input  logic [ACC_W-1:0] mac_acc_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACC_W-1:0] result_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         rr_q;
  logic [ACC_W-1:0]   result_q;

  logic [1:0]         idx0, idx1, idx2;
  logic [1:0]         gnt_idx;
  logic [2:0]         grant;
  logic               gnt_any;
  logic               last_term;

  // Modulo-3 increment for the 0..2 round-robin pointer.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search order starting at the round-robin pointer.
  assign idx0 = rr_q;
  assign idx1 = inc3(rr_q);
  assign idx2 = inc3(idx1);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant   = 3'b000;
    gnt_idx = 2'd0;
    if (state_q == S_RUN && !abort_i) begin
      if (req_i[idx0]) begin
        grant   = 3'b001 << idx0;
        gnt_idx = idx0;
      end else if (req_i[idx1]) begin
        grant   = 3'b001 << idx1;
        gnt_idx = idx1;
      end else if (req_i[idx2]) begin
        grant   = 3'b001 << idx2;
        gnt_idx = idx2;
      end
    end
  end

  assign gnt_any   = |grant;
  // len_q is never 0 in RUN, so len_q-1 cannot underflow here.
  assign last_term = (cnt_q == len_q - LEN_W'(1));

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      rr_q     <= 2'd0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              len_q   <= len_i;
              state_q <= S_CLEAR;
            end else begin
              // Empty job: report a zero result without touching the MAC.
              result_q <= '0;
              state_q  <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          if (abort_i) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            state_q <= S_IDLE;
          end else if (gnt_any) begin
            cnt_q <= cnt_q + LEN_W'(1);
            rr_q  <= inc3(gnt_idx);
            if (last_term) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The final term was accumulated at the end of the last RUN cycle.
          if (abort_i) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= mac_acc_i;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_o     = grant;
  assign mac_valid_o = grant;
  assign mac_clear_o = (state_q == S_CLEAR) && !abort_i;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_mac_sched.sv
// ---------------------------------------------------------------------------
// tb_mac_sched -- directed, self-checking bench for mac_sched.
// A small behavioural MAC (registered accumulator with clear) closes the loop;
// expected job results are queued when a job is launched and popped when
// done_o is seen.
// ---------------------------------------------------------------------------
module tb_mac_sched;

  localparam int ACC_W = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             abort = 1'b0;
  logic [2:0]       req = 3'b000;
  logic [2:0]       grant;
  logic             mac_clear;
  logic [2:0]       mac_valid;
  logic [ACC_W-1:0] mac_acc;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] term [3];
  logic [ACC_W-1:0] acc_m = '0;
  logic [ACC_W-1:0] exp_q [$];
  logic [2:0]       gnt_log [$];
  int               clear_cnt = 0;
  int               done_cnt = 0;

  mac_sched #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .len_i       (len),
    .abort_i     (abort),
    .req_i       (req),
    .grant_o     (grant),
    .mac_clear_o (mac_clear),
    .mac_valid_o (mac_valid),
    .mac_acc_i   (mac_acc),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: each lane carries a fixed product value term[i].
  always @(posedge clk) begin
    if (mac_clear) acc_m <= '0;
    else acc_m <= acc_m + (mac_valid[0] ? term[0] : 16'd0)
                        + (mac_valid[1] ? term[1] : 16'd0)
                        + (mac_valid[2] ? term[2] : 16'd0);
  end
  assign mac_acc = acc_m;

  // Monitors sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (grant != 3'b000) gnt_log.push_back(grant);
    if (mac_clear) clear_cnt <= clear_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_cycle(input int c, input bit toggle, input int restart_at);
    if (toggle) req = (c % 2 == 0) ? 3'b001 : 3'b000;
    start = (c == restart_at);
  endtask

  // Launch a job in the current cycle (cycle 0) and wait for done_o.
  // lat returns the cycle index in which done_o was observed.
  task automatic run_job(input logic [LEN_W-1:0] n, input logic [ACC_W-1:0] exp_res,
                         input bit toggle, input int restart_at, output int lat);
    start = 1'b1;
    len   = n;
    exp_q.push_back(exp_res);
    tick();
    lat = 1;
    drive_cycle(lat, toggle, restart_at);
    #1;
    while (done !== 1'b1 && lat < 300) begin
      tick();
      lat++;
      drive_cycle(lat, toggle, restart_at);
      #1;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    if (exp_q.size() > 0) check("result", result, exp_q.pop_front());
  endtask

  initial begin
    int lat;
    int base;
    int c0;
    int d0;

    term[0] = 16'd6;
    term[1] = 16'd12;
    term[2] = 16'd15;
    req     = 3'b111;

    // Reset state, checked while reset is held.
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_grant", grant, 0);
    check("rst_clear", mac_clear, 0);
    check("rst_result", result, 0);
    #12 rst_n = 1'b1;
    tick();
    check("idle_grant", grant, 0);

    // Scenario 1: all requesting, len=3, terms 6/12/15.
    start = 1'b1; len = 8'd3; exp_q.push_back(16'd33);
    #1 check("s1_c0_busy", busy, 0);
    tick(); start = 1'b0;
    #1 check("s1_c1_clear", mac_clear, 1);
    check("s1_c1_grant", grant, 0);
    check("s1_c1_busy", busy, 1);
    tick(); #1 check("s1_c2_grant", grant, 3'b001);
    check("s1_c2_valid", mac_valid, 3'b001);
    tick(); #1 check("s1_c3_grant", grant, 3'b010);
    tick(); #1 check("s1_c4_grant", grant, 3'b100);
    tick(); #1 check("s1_c5_grant", grant, 0);
    check("s1_c5_done", done, 0);
    tick(); #1 check("s1_c6_done", done, 1);
    check("s1_result", result, exp_q.pop_front());
    tick(); #1 check("s1_c7_done", done, 0);
    check("s1_c7_busy", busy, 0);

    // Scenario 2: lane 1 only, len=4, term 7; then len=1 with all requesting.
    tick();
    req = 3'b010; term[1] = 16'd7;
    base = gnt_log.size();
    run_job(8'd4, 16'd28, 1'b0, -1, lat);
    check("s2_latency", lat, 7);
    check("s2_ngrants", gnt_log.size() - base, 4);
    for (int i = 0; i < 4; i++) check("s2_grant", gnt_log[base + i], 3'b010);
    tick();
    req = 3'b111; term[1] = 16'd12;
    base = gnt_log.size();
    run_job(8'd1, 16'd15, 1'b0, -1, lat);
    check("s2b_latency", lat, 4);
    check("s2b_grant", gnt_log[base], 3'b100);

    // Scenario 3: lane 0 toggling, len=5, term 3 -> 4 idle RUN cycles.
    tick();
    req = 3'b000; term[0] = 16'd3;
    base = gnt_log.size();
    run_job(8'd5, 16'd15, 1'b1, -1, lat);
    check("s3_latency", lat, 12);
    check("s3_ngrants", gnt_log.size() - base, 5);

    // Scenario 4: len=0, then len=4 with a stray start mid-job.
    tick();
    req = 3'b111; term[0] = 16'd6;
    c0 = clear_cnt; d0 = done_cnt;
    run_job(8'd0, 16'd0, 1'b0, -1, lat);
    check("s4_len0_latency", lat, 1);
    tick();
    check("s4_len0_noclear", clear_cnt, c0);
    check("s4_len0_ndone", done_cnt, d0 + 1);
    d0 = done_cnt;
    // rr=1 after scenario 3: grants 010,100,001,010 -> 12+15+6+12.
    run_job(8'd4, 16'd45, 1'b0, 3, lat);
    check("s4_latency", lat, 7);
    repeat (6) tick();
    check("s4_one_done", done_cnt, d0 + 1);
    check("s4_idle", busy, 0);

    // Scenario 5: abort in the second RUN cycle of a len=6 job.
    start = 1'b1; len = 8'd6;
    d0 = done_cnt;
    tick(); start = 1'b0;
    tick(); #1 check("s5_run1_grant", grant, 3'b100);
    tick(); abort = 1'b1;
    #1 check("s5_abort_grant", grant, 0);
    check("s5_abort_clear", mac_clear, 0);
    check("s5_abort_busy", busy, 1);
    tick(); abort = 1'b0;
    #1 check("s5_post_busy", busy, 0);
    repeat (3) tick();
    check("s5_no_done", done_cnt, d0);
    check("s5_result_held", result, 45);
    c0 = clear_cnt;
    run_job(8'd2, 16'd18, 1'b0, -1, lat);
    check("s5b_latency", lat, 5);
    check("s5b_clear", clear_cnt, c0 + 1);

    // Scenario 6: asynchronous reset during RUN, then a fresh job.
    tick();
    start = 1'b1; len = 8'd3;
    tick(); start = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1 check("s6_rst_grant", grant, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_result", result, 0);
    check("s6_rst_done", done, 0);
    #2 rst_n = 1'b1;
    tick();
    base = gnt_log.size();
    run_job(8'd3, 16'd33, 1'b0, -1, lat);
    check("s6_latency", lat, 6);
    check("s6_g0", gnt_log[base], 3'b001);
    check("s6_g1", gnt_log[base + 1], 3'b010);
    check("s6_g2", gnt_log[base + 2], 3'b100);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
